// File: rtl/perceptron_host.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_host
//  Description : Initiator-side controller for perceptron_top. Buffers
//                labelled samples in a FIFO, issues them one at a time,
//                compares each returned Y against its label, counts errors
//                and forwards results downstream.
//                Optional macro PERC_TRAIN_EN enables weight retraining
//                after each misclassified sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_host #(
    parameter int   WIDTH   = 8,
    parameter int   DEPTH   = 4,
    parameter int   CNT_W   = 16,
    parameter logic INIT_B  = 1'b0,
    parameter logic INIT_W0 = 1'b1,
    parameter logic INIT_W1 = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_val_i,
    output logic             s_rdy_o,
    input  logic [WIDTH-1:0] s_X0_i,
    input  logic [WIDTH-1:0] s_X1_i,
    input  logic             s_label_i,
    output logic             p_val_o,
    input  logic             p_rdy_i,
    output logic [WIDTH-1:0] p_X0_o,
    output logic [WIDTH-1:0] p_X1_o,
    output logic [1:0]       p_W1W0b_en_o,
    output logic             p_b_o,
    output logic             p_W0_o,
    output logic             p_W1_o,
    input  logic             p_val_i,
    output logic             p_rdy_o,
    input  logic             p_Y_i,
    output logic             r_val_o,
    input  logic             r_rdy_i,
    output logic             r_Y_o,
    output logic             r_err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + 1;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_SEND   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    // ---------------------------------------------------------------- state
    logic [2:0]       state_q,   state_d;
    logic [1:0]       step_q,    step_d;
    logic [1:0]       en_q,      en_d;
    logic [WIDTH-1:0] x0_q,      x0_d;
    logic [WIDTH-1:0] x1_q,      x1_d;
    logic             label_q,   label_d;
    logic             y_q,       y_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             b_q,       b_d;
    logic             w0_q,      w0_d;
    logic             w1_q,      w1_d;

    // ----------------------------------------------------------------- FIFO
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic             mismatch;

    // FIFO status: one extra pointer bit distinguishes full from empty
    always_comb begin
        fifo_cnt   = wr_ptr_q - rd_ptr_q;
        fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        s_rdy_o    = (state_q != ST_INIT) && !fifo_full;
        push       = s_val_i && s_rdy_o;
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        head       = mem_q[rd_ptr_q[AW-1:0]];
    end

    // FIFO next-state: write entry {label, X1, X0} at tail, advance pointers
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {s_label_i, s_X1_i, s_X0_i};
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    assign mismatch = y_q ^ label_q;

    // Controller: weight-load sequencing, sample issue, result report
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        en_d      = 2'b00;
        x0_d      = x0_q;
        x1_d      = x1_q;
        label_d   = label_q;
        y_d       = y_q;
        err_cnt_d = err_cnt_q;
        b_d       = b_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        case (state_q)
            // Load sequence b, W0, W1 (step 0..2), then one idle step so the
            // last pulse is visible before leaving; step 3 wraps en to 00.
            ST_INIT, ST_UPDATE: begin
                en_d   = step_q + 2'd1;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    x0_d    = head[WIDTH-1:0];
                    x1_d    = head[2*WIDTH-1:WIDTH];
                    label_d = head[EW-1];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (p_rdy_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (p_val_i) begin
                    y_d     = p_Y_i;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (r_rdy_i) begin
                    if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_d = ST_IDLE;
`ifdef PERC_TRAIN_EN
                    // Shadow weights change first so the reload pulses
                    // carry the new values. Sign of X is its MSB.
                    if (mismatch) begin
                        b_d     = label_q;
                        w0_d    = (!x0_q[WIDTH-1]) == label_q;
                        w1_d    = (!x1_q[WIDTH-1]) == label_q;
                        step_d  = 2'd0;
                        state_d = ST_UPDATE;
                    end
`else
`endif
                end
            end
            default: begin
                state_d = ST_INIT;
                step_d  = 2'd0;
            end
        endcase
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            step_q    <= 2'd0;
            en_q      <= 2'b00;
            x0_q      <= '0;
            x1_q      <= '0;
            label_q   <= 1'b0;
            y_q       <= 1'b0;
            err_cnt_q <= '0;
            b_q       <= INIT_B;
            w0_q      <= INIT_W0;
            w1_q      <= INIT_W1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            en_q      <= en_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            label_q   <= label_d;
            y_q       <= y_d;
            err_cnt_q <= err_cnt_d;
            b_q       <= b_d;
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Output decode, all driven from registers
    always_comb begin
        p_val_o      = (state_q == ST_SEND);
        p_rdy_o      = (state_q == ST_WAIT);
        r_val_o      = (state_q == ST_REPORT);
        busy_o       = (state_q != ST_IDLE);
        p_X0_o       = x0_q;
        p_X1_o       = x1_q;
        p_W1W0b_en_o = en_q;
        p_b_o        = b_q;
        p_W0_o       = w0_q;
        p_W1_o       = w1_q;
        r_Y_o        = y_q;
        r_err_o      = mismatch;
        err_cnt_o    = err_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perceptron_host
//  Description : Directed self-checking bench for perceptron_host. The
//                perceptron side is driven directly (p_rdy_i/p_val_i/p_Y_i).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_host;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_val_i = 1'b0;
    logic       s_rdy_o;
    logic [7:0] s_X0_i = '0;
    logic [7:0] s_X1_i = '0;
    logic       s_label_i = 1'b0;
    logic       p_val_o;
    logic       p_rdy_i = 1'b0;
    logic [7:0] p_X0_o;
    logic [7:0] p_X1_o;
    logic [1:0] p_W1W0b_en_o;
    logic       p_b_o;
    logic       p_W0_o;
    logic       p_W1_o;
    logic       p_val_i = 1'b0;
    logic       p_rdy_o;
    logic       p_Y_i = 1'b0;
    logic       r_val_o;
    logic       r_rdy_i = 1'b0;
    logic       r_Y_o;
    logic       r_err_o;
    logic [15:0] err_cnt_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;

    perceptron_host dut (
        .clk(clk), .reset(reset),
        .s_val_i(s_val_i), .s_rdy_o(s_rdy_o),
        .s_X0_i(s_X0_i), .s_X1_i(s_X1_i), .s_label_i(s_label_i),
        .p_val_o(p_val_o), .p_rdy_i(p_rdy_i),
        .p_X0_o(p_X0_o), .p_X1_o(p_X1_o),
        .p_W1W0b_en_o(p_W1W0b_en_o),
        .p_b_o(p_b_o), .p_W0_o(p_W0_o), .p_W1_o(p_W1_o),
        .p_val_i(p_val_i), .p_rdy_o(p_rdy_o), .p_Y_i(p_Y_i),
        .r_val_o(r_val_o), .r_rdy_i(r_rdy_i),
        .r_Y_o(r_Y_o), .r_err_o(r_err_o),
        .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; observe 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until accepted (bounded)
    task automatic push(input logic [7:0] x0, input logic [7:0] x1, input logic lbl);
        int waited;
        s_val_i = 1'b1; s_X0_i = x0; s_X1_i = x1; s_label_i = lbl;
        waited = 0;
        while (!s_rdy_o && waited < 100) begin
            tick;
            waited++;
        end
        n_vec++;
        if (s_rdy_o !== 1'b1) begin
            n_err++;
            $display("FAIL push_timeout: s_rdy_o=%b required 1", s_rdy_o);
        end
        tick;
        s_val_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [1:0] exp_en;
        reset = 1'b1;
        tick; tick;
        n_vec++;
        if ({busy_o, s_rdy_o} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_flags: busy,s_rdy=%b required 10", {busy_o, s_rdy_o});
        end
        n_vec++;
        if ({p_val_o, p_rdy_o, r_val_o, p_W1W0b_en_o} !== 5'b0 || err_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: pval,prdy,rval,en=%b cnt=%0d required 0",
                     {p_val_o, p_rdy_o, r_val_o, p_W1W0b_en_o}, err_cnt_o);
        end
        n_vec++;
        if ({p_b_o, p_W0_o, p_W1_o} !== 3'b011) begin
            n_err++;
            $display("FAIL reset_weights: b,w0,w1=%b required 011", {p_b_o, p_W0_o, p_W1_o});
        end
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            exp_en = (c == 4) ? 2'b00 : 2'(c);
            n_vec++;
            if (p_W1W0b_en_o !== exp_en || s_rdy_o !== (c == 4) || busy_o !== (c != 4)) begin
                n_err++;
                $display("FAIL init_seq cycle %0d: en=%b s_rdy=%b busy=%b required en=%b s_rdy=%b busy=%b",
                         c, p_W1W0b_en_o, s_rdy_o, busy_o, exp_en, (c == 4), (c != 4));
            end
        end
    endtask

    task automatic test_single;
        p_rdy_i = 1'b1; p_val_i = 1'b1; p_Y_i = 1'b1; r_rdy_i = 1'b1;
        push(8'd5, 8'hFD, 1'b1);
        // IDLE with the sample in the FIFO
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy=%b required 0", busy_o);
        end
        tick;
        n_vec++;
        if (p_val_o !== 1'b1 || p_X0_o !== 8'd5 || p_X1_o !== 8'hFD) begin
            n_err++;
            $display("FAIL single_send: pval=%b x0=%h x1=%h required 1 05 fd", p_val_o, p_X0_o, p_X1_o);
        end
        tick;
        n_vec++;
        if (p_rdy_o !== 1'b1 || p_val_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_wait: prdy=%b pval=%b required 1 0", p_rdy_o, p_val_o);
        end
        tick;
        n_vec++;
        if (r_val_o !== 1'b1 || r_Y_o !== 1'b1 || r_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_report: rval=%b Y=%b err=%b required 1 1 0", r_val_o, r_Y_o, r_err_o);
        end
        tick;
        n_vec++;
        if (busy_o !== 1'b0 || r_val_o !== 1'b0 || err_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL single_latency: busy=%b rval=%b cnt=%0d required 0 0 0", busy_o, r_val_o, err_cnt_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_x0 [6];
        int accepted;
        int idx;
        int cyc;
        for (int k = 0; k < 6; k++) exp_x0[k] = 8'(10 + k);
        p_rdy_i = 1'b0; p_val_i = 1'b1; p_Y_i = 1'b1; r_rdy_i = 1'b1;
        // First sample parks in SEND while the perceptron is not ready
        push(8'd10, 8'd1, 1'b1);
        tick;
        n_vec++;
        if (p_val_o !== 1'b1 || p_X0_o !== 8'd10) begin
            n_err++;
            $display("FAIL b2b_park: pval=%b x0=%0d required 1 10", p_val_o, p_X0_o);
        end
        accepted = 0;
        for (int k = 1; k <= 5; k++) begin
            s_val_i = 1'b1; s_X0_i = 8'(10 + k); s_X1_i = 8'd1; s_label_i = 1'b1;
            if (s_rdy_o) accepted++;
            if (k < 5) tick;
        end
        n_vec++;
        if (accepted !== 4 || s_rdy_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: accepted=%0d s_rdy=%b required 4 0", accepted, s_rdy_o);
        end
        // Release the perceptron; keep offering the 5th until taken
        p_rdy_i = 1'b1;
        idx = 0;
        cyc = 0;
        while ((idx < 6 || s_val_i || busy_o) && cyc < 200) begin
            if (p_val_o && p_rdy_i) begin
                n_vec++;
                if (idx >= 6 || p_X0_o !== exp_x0[idx]) begin
                    n_err++;
                    $display("FAIL b2b_order[%0d]: x0=%0d required %0d", idx, p_X0_o,
                             (idx < 6) ? exp_x0[idx] : 8'hxx);
                end
                idx++;
            end
            if (s_val_i && s_rdy_o) begin
                tick;
                s_val_i = 1'b0;
            end else begin
                tick;
            end
            cyc++;
        end
        n_vec++;
        if (idx !== 6 || busy_o !== 1'b0 || err_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL b2b_drain: issued=%0d busy=%b cnt=%0d required 6 0 0", idx, busy_o, err_cnt_o);
        end
    endtask

    task automatic test_report_stall;
        bit stable;
        p_rdy_i = 1'b1; p_val_i = 1'b1; p_Y_i = 1'b0; r_rdy_i = 1'b0;
        push(8'd1, 8'd2, 1'b1);
        push(8'd3, 8'd4, 1'b0);
        for (int i = 0; i < 50 && !r_val_o; i++) tick;
        n_vec++;
        if (r_val_o !== 1'b1 || r_Y_o !== 1'b0 || r_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL stall_report: rval=%b Y=%b err=%b required 1 0 1", r_val_o, r_Y_o, r_err_o);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (r_val_o !== 1'b1 || r_Y_o !== 1'b0 || r_err_o !== 1'b1 || p_val_o !== 1'b0) stable = 1'b0;
        end
        n_vec++;
        if (!stable) begin
            n_err++;
            $display("FAIL stall_hold: rval=%b Y=%b pval=%b required 1 0 0", r_val_o, r_Y_o, p_val_o);
        end
        r_rdy_i = 1'b1;
        tick;
        n_vec++;
        if (err_cnt_o !== 16'd1 || r_val_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_count: cnt=%0d rval=%b required 1 0", err_cnt_o, r_val_o);
        end
        // Queued second sample (label 0, Y 0) reports no error
        for (int i = 0; i < 50 && !r_val_o; i++) tick;
        n_vec++;
        if (r_val_o !== 1'b1 || r_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_second: rval=%b err=%b required 1 0", r_val_o, r_err_o);
        end
        tick;
        n_vec++;
        if (busy_o !== 1'b0 || err_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL stall_after: busy=%b cnt=%0d required 0 1", busy_o, err_cnt_o);
        end
    endtask

    task automatic test_train;
        logic [1:0] exp_en;
        p_rdy_i = 1'b1; p_val_i = 1'b1; p_Y_i = 1'b1; r_rdy_i = 1'b1;
        push(8'hFC, 8'd7, 1'b0);
        for (int i = 0; i < 50 && !r_val_o; i++) tick;
        n_vec++;
        if (r_val_o !== 1'b1 || r_Y_o !== 1'b1 || r_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL train_report: rval=%b Y=%b err=%b required 1 1 1", r_val_o, r_Y_o, r_err_o);
        end
        tick;
        n_vec++;
        if (err_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL train_count: cnt=%0d required 2", err_cnt_o);
        end
`ifdef PERC_TRAIN_EN
        n_vec++;
        if ({p_b_o, p_W0_o, p_W1_o} !== 3'b010 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL train_weights: b,w0,w1=%b busy=%b required 010 1", {p_b_o, p_W0_o, p_W1_o}, busy_o);
        end
        for (int c = 1; c <= 4; c++) begin
            tick;
            exp_en = (c == 4) ? 2'b00 : 2'(c);
            n_vec++;
            if (p_W1W0b_en_o !== exp_en || busy_o !== (c != 4) || {p_b_o, p_W0_o, p_W1_o} !== 3'b010) begin
                n_err++;
                $display("FAIL train_reload cycle %0d: en=%b busy=%b w=%b required en=%b busy=%b w=010",
                         c, p_W1W0b_en_o, busy_o, {p_b_o, p_W0_o, p_W1_o}, exp_en, (c != 4));
            end
        end
`else
        exp_en = 2'b00;
        n_vec++;
        if ({p_b_o, p_W0_o, p_W1_o} !== 3'b011 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL notrain_weights: b,w0,w1=%b busy=%b required 011 0", {p_b_o, p_W0_o, p_W1_o}, busy_o);
        end
        for (int c = 1; c <= 4; c++) begin
            tick;
            n_vec++;
            if (p_W1W0b_en_o !== exp_en) begin
                n_err++;
                $display("FAIL notrain_pulse cycle %0d: en=%b required 00", c, p_W1W0b_en_o);
            end
        end
`endif
    endtask

    task automatic test_reset_in_wait;
        logic [1:0] exp_en;
        bit quiet;
        p_rdy_i = 1'b1; p_val_i = 1'b0; r_rdy_i = 1'b1;
        push(8'd20, 8'd21, 1'b1);
        push(8'd22, 8'd23, 1'b1);
        for (int i = 0; i < 50 && !p_rdy_o; i++) tick;
        n_vec++;
        if (p_rdy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_reach: prdy=%b required 1", p_rdy_o);
        end
        reset = 1'b1;
        tick;
        n_vec++;
        if ({busy_o, s_rdy_o, p_rdy_o, r_val_o, p_val_o} !== 5'b10000 || err_cnt_o !== 16'd0
            || {p_b_o, p_W0_o, p_W1_o} !== 3'b011) begin
            n_err++;
            $display("FAIL rstwait_state: busy,srdy,prdy,rval,pval=%b cnt=%0d w=%b required 10000 0 011",
                     {busy_o, s_rdy_o, p_rdy_o, r_val_o, p_val_o}, err_cnt_o, {p_b_o, p_W0_o, p_W1_o});
        end
        reset = 1'b0;
        p_val_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            exp_en = (c == 4) ? 2'b00 : 2'(c);
            n_vec++;
            if (p_W1W0b_en_o !== exp_en || s_rdy_o !== (c == 4)) begin
                n_err++;
                $display("FAIL rstwait_init cycle %0d: en=%b s_rdy=%b required en=%b s_rdy=%b",
                         c, p_W1W0b_en_o, s_rdy_o, exp_en, (c == 4));
            end
        end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (p_val_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
            tick;
        end
        n_vec++;
        if (!quiet) begin
            n_err++;
            $display("FAIL rstwait_fifo_empty: pval=%b busy=%b required 0 0", p_val_o, busy_o);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_report_stall;
        test_train;
        test_reset_in_wait;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
